// File: rtl/simu_trig_pkg.sv
// Shared types and defaults for the simulated-trigger scheduler.
package simu_trig_pkg;

    localparam int unsigned CW_DEF        = 16;
    localparam int unsigned PULSE_LEN_DEF = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_PULSE,
        ST_DEAD,
        ST_DONE
    } state_t;

    // Width of a source index; at least one bit even for two sources.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/simu_rr_arb.sv
// Combinational round-robin pick: first pending bit at or above rr_ptr, wrapping.
module simu_rr_arb
    import simu_trig_pkg::*;
#(
    parameter int unsigned N_SRC = 4,
    parameter int unsigned IW    = grant_w(N_SRC)
) (
    input  logic [N_SRC-1:0] pending,
    input  logic [IW-1:0]    rr_ptr,
    output logic             any_grant,
    output logic [IW-1:0]    grant_idx
);

    logic [IW-1:0] w_idx;

    always_comb begin
        any_grant = 1'b0;
        grant_idx = '0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            w_idx = IW'((32'(rr_ptr) + k) % N_SRC);
            if (!any_grant && pending[w_idx]) begin
                any_grant = 1'b1;
                grant_idx = w_idx;
            end
        end
    end

endmodule

// File: rtl/simu_trig_sched.sv
// Round-robin scheduler sharing one trigger line between N simulated trigger sources,
// with fixed pulse length, programmable deadtime and per-run statistics.
module simu_trig_sched
    import simu_trig_pkg::*;
#(
    parameter  int unsigned N_SRC     = 4,
    parameter  int unsigned PULSE_LEN = PULSE_LEN_DEF,
    parameter  int unsigned CW        = CW_DEF,
    localparam int unsigned IW        = grant_w(N_SRC)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [CW-1:0]    n_trig,
    input  logic [CW-1:0]    deadtime,
    input  logic [N_SRC-1:0] req,
    output logic             trigger,
    output logic [IW-1:0]    grant_id,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    trig_count,
    output logic [CW-1:0]    lost_count
);

    localparam int unsigned PW      = $clog2(PULSE_LEN + 1);
    localparam int unsigned TW      = (CW > PW) ? CW : PW;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t           r_state, w_state_nxt;
    logic [TW-1:0]    r_tmr, w_tmr_nxt;
    logic [N_SRC-1:0] r_pend, w_pend_nxt;
    logic [IW-1:0]    r_rr, w_rr_nxt;
    logic [IW-1:0]    r_gid, w_gid_nxt;
    logic [CW-1:0]    r_ntrig, w_ntrig_nxt;
    logic [CW-1:0]    r_dead, w_dead_nxt;
    logic [CW-1:0]    r_tc, w_tc_nxt;
    logic [CW-1:0]    r_lost, w_lost_nxt;
    logic             r_stop_seen, w_stop_seen_nxt;
    logic             r_trig, r_busy, r_done;

    logic             w_any;
    logic [IW-1:0]    w_gidx;
    logic [N_SRC-1:0] w_clr, w_lost_hit;
    logic             w_capture;
    logic [CW-1:0]    w_tc_inc;

    simu_rr_arb #(
        .N_SRC (N_SRC),
        .IW    (IW)
    ) u_arb (
        .pending   (r_pend),
        .rr_ptr    (r_rr),
        .any_grant (w_any),
        .grant_idx (w_gidx)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_tmr_nxt       = r_tmr;
        w_pend_nxt      = r_pend;
        w_rr_nxt        = r_rr;
        w_gid_nxt       = r_gid;
        w_ntrig_nxt     = r_ntrig;
        w_dead_nxt      = r_dead;
        w_tc_nxt        = r_tc;
        w_lost_nxt      = r_lost;
        w_stop_seen_nxt = r_stop_seen;
        w_clr           = '0;
        w_capture       = 1'b0;
        w_lost_hit      = '0;
        w_tc_inc        = r_tc + CW'(1);

        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (start) begin
                    w_state_nxt = ST_ARM;
                    w_ntrig_nxt = n_trig;
                    w_dead_nxt  = deadtime;
                    w_tc_nxt    = '0;
                    w_lost_nxt  = '0;
                    w_pend_nxt  = '0;
                end
            end
            ST_ARM: begin
                w_capture = 1'b1;
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_any) begin
                    w_state_nxt     = ST_PULSE;
                    w_gid_nxt       = w_gidx;
                    w_clr[w_gidx]   = 1'b1;
                    w_rr_nxt        = (w_gidx == IW'(N_SRC - 1)) ? '0 : w_gidx + IW'(1);
                    w_tmr_nxt       = TW'(PULSE_LEN - 1);
                    w_stop_seen_nxt = 1'b0;
                end
            end
            ST_PULSE: begin
                // A pulse always runs to completion; stop only takes effect at its end.
                w_capture = 1'b1;
                if (stop) w_stop_seen_nxt = 1'b1;
                if (r_tmr == '0) begin
                    w_tc_nxt = w_tc_inc;
                    if (r_stop_seen || stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_ntrig != '0 && w_tc_inc == r_ntrig) begin
                        w_state_nxt = ST_DONE;
                    end else if (r_dead == '0) begin
                        w_state_nxt = ST_ARM;
                    end else begin
                        w_state_nxt = ST_DEAD;
                        w_tmr_nxt   = TW'(r_dead) - TW'(1);
                    end
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            ST_DEAD: begin
                w_capture = 1'b1;
                if (stop) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tmr == '0) begin
                    w_state_nxt = ST_ARM;
                end else begin
                    w_tmr_nxt = r_tmr - TW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A request to an already pending source is lost unless that source is granted now.
        if (w_capture) begin
            w_lost_hit = req & r_pend & ~w_clr;
            w_pend_nxt = (r_pend & ~w_clr) | req;
            for (int unsigned i = 0; i < N_SRC; i++) begin
                if (w_lost_hit[i] && w_lost_nxt != CNT_MAX) w_lost_nxt = w_lost_nxt + CW'(1);
            end
        end

        if (w_state_nxt == ST_IDLE) w_pend_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_pend      <= '0;
            r_rr        <= '0;
            r_gid       <= '0;
            r_ntrig     <= '0;
            r_dead      <= '0;
            r_tc        <= '0;
            r_lost      <= '0;
            r_stop_seen <= 1'b0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_pend      <= w_pend_nxt;
            r_rr        <= w_rr_nxt;
            r_gid       <= w_gid_nxt;
            r_ntrig     <= w_ntrig_nxt;
            r_dead      <= w_dead_nxt;
            r_tc        <= w_tc_nxt;
            r_lost      <= w_lost_nxt;
            r_stop_seen <= w_stop_seen_nxt;
            r_trig      <= (w_state_nxt == ST_PULSE);
            r_busy      <= (w_state_nxt == ST_ARM) || (w_state_nxt == ST_PULSE) ||
                           (w_state_nxt == ST_DEAD);
            r_done      <= (w_state_nxt == ST_DONE);
        end
    end

    assign trigger    = r_trig;
    assign grant_id   = r_gid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign trig_count = r_tc;
    assign lost_count = r_lost;

endmodule

// File: tb/tb_simu_trig_sched.sv
// Self-checking bench for simu_trig_sched: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural scheduler model.
module tb_simu_trig_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned PL   = 9;
    localparam int unsigned CW   = 4;
    localparam int unsigned IW   = 2;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop;
    logic [CW-1:0] n_trig, deadtime;
    logic [N-1:0]  req;
    logic          trigger, busy, done;
    logic [IW-1:0] grant_id;
    logic [CW-1:0] trig_count, lost_count;

    always #5 clk = ~clk;

    simu_trig_sched #(
        .N_SRC     (N),
        .PULSE_LEN (PL),
        .CW        (CW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .n_trig     (n_trig),
        .deadtime   (deadtime),
        .req        (req),
        .trigger    (trigger),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done),
        .trig_count (trig_count),
        .lost_count (lost_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: run phases, up-counting ages, pending flags as a bit array.
    typedef enum int {PH_IDLE, PH_WAIT, PH_HIGH, PH_GAP, PH_FIN} phase_t;
    phase_t ph;
    int     age, m_ntrig, m_dead, m_tc, m_lost, m_gid, m_rr;
    bit     m_pend[N];
    bit     m_stop_seen;

    task automatic model_reset();
        ph = PH_IDLE; age = 0; m_ntrig = 0; m_dead = 0; m_tc = 0; m_lost = 0;
        m_gid = 0; m_rr = 0; m_stop_seen = 0;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    task automatic model_step();
        int g;
        bit cap;
        g   = -1;
        cap = (ph == PH_WAIT) || (ph == PH_HIGH) || (ph == PH_GAP);
        case (ph)
            PH_IDLE, PH_FIN: begin
                if (stop) ph = PH_IDLE;
                else if (start) begin
                    ph = PH_WAIT; m_ntrig = int'(n_trig); m_dead = int'(deadtime);
                    m_tc = 0; m_lost = 0;
                    for (int i = 0; i < N; i++) m_pend[i] = 0;
                end
            end
            PH_WAIT: begin
                if (stop) ph = PH_IDLE;
                else begin
                    for (int k = 0; k < N; k++) begin
                        int j = (m_rr + k) % N;
                        if (g < 0 && m_pend[j]) g = j;
                    end
                    if (g >= 0) begin
                        m_gid = g; m_rr = (g + 1) % N; m_pend[g] = 0;
                        ph = PH_HIGH; age = 1; m_stop_seen = 0;
                    end
                end
            end
            PH_HIGH: begin
                if (stop) m_stop_seen = 1;
                if (age == PL) begin
                    m_tc = (m_tc + 1) % (CMAX + 1);
                    if (m_stop_seen) ph = PH_IDLE;
                    else if (m_ntrig != 0 && m_tc == m_ntrig) ph = PH_FIN;
                    else if (m_dead == 0) ph = PH_WAIT;
                    else begin ph = PH_GAP; age = 1; end
                end else age++;
            end
            PH_GAP: begin
                if (stop) ph = PH_IDLE;
                else if (age == m_dead) ph = PH_WAIT;
                else age++;
            end
            default: ph = PH_IDLE;
        endcase
        if (cap) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_pend[i] && m_lost < CMAX) m_lost++;
                    m_pend[i] = 1;
                end
            end
        end
        if (ph == PH_IDLE) for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    task automatic compare_all();
        check_eq("trigger",    32'(trigger),    32'(ph == PH_HIGH));
        check_eq("busy",       32'(busy),       32'(ph == PH_WAIT || ph == PH_HIGH || ph == PH_GAP));
        check_eq("done",       32'(done),       32'(ph == PH_FIN));
        check_eq("grant_id",   32'(grant_id),   32'(m_gid));
        check_eq("trig_count", 32'(trig_count), 32'(m_tc));
        check_eq("lost_count", 32'(lost_count), 32'(m_lost));
    endtask

    int hi_cnt = 0;
    bit prev_trig = 0;
    int gq[$];

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        @(negedge clk);
        compare_all();
        if (trigger === 1'b1) hi_cnt++;
        if (trigger === 1'b1 && !prev_trig) gq.push_back(int'(grant_id));
        prev_trig = (trigger === 1'b1);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_trig(input int maxc);
        int c = 0;
        while (trigger !== 1'b1 && c < maxc) begin tick(); c++; end
        if (trigger !== 1'b1) check_eq("wait_trig_timeout", 32'(trigger), 32'd1);
    endtask

    task automatic pulse_start(input int nt, input int dt);
        n_trig = CW'(nt); deadtime = CW'(dt); start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; n_trig = '0; deadtime = '0; req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b1;
        run(2);

        // Fairness: all sources at once, free-run, zero deadtime.
        pulse_start(0, 0);
        gq.delete();
        req = 4'b1111;
        tick();
        req = '0;
        run(45);
        check_eq("s2_grants_seen", 32'(gq.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            if (k < gq.size()) check_eq("s2_grant_order", 32'(gq[k]), 32'(k));
        check_eq("s2_lost_zero", 32'(lost_count), 32'd0);
        stop = 1'b1; tick(); stop = 1'b0;
        run(3);

        // Single source, three triggers with deadtime 5.
        pulse_start(3, 5);
        hi_cnt = 0;
        for (int c = 0; c < 120 && done !== 1'b1; c++) begin
            req = (c % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
        end
        req = '0;
        check_eq("s1_done",         32'(done),              32'd1);
        check_eq("s1_trig_count",   32'(trig_count),        32'd3);
        check_eq("s1_grant_id",     32'(grant_id),          32'd0);
        check_eq("s1_high_cycles",  32'(hi_cnt),            32'd27);
        check_eq("s1_lost_nonzero", 32'(lost_count != '0), 32'd1);
        run(3);

        // Loss saturation with a held request.
        pulse_start(0, 2);
        req = 4'b0010;
        run(40);
        req = '0;
        check_eq("s3_lost_sat", 32'(lost_count), 32'(CMAX));
        stop = 1'b1; tick(); stop = 1'b0;
        run(15);
        check_eq("s3_idle", 32'(busy), 32'd0);

        // Stop on the third high cycle of a pulse.
        pulse_start(0, 3);
        hi_cnt = 0;
        req = 4'b0001; tick(); req = '0;
        wait_trig(10);
        run(2);
        stop = 1'b1; tick(); stop = 1'b0;
        run(12);
        check_eq("s4_full_pulse", 32'(hi_cnt), 32'd9);
        check_eq("s4_idle",       32'(busy),   32'd0);
        hi_cnt = 0;
        req = 4'b0100; tick(); req = '0;
        run(10);
        check_eq("s4_no_trig_after_stop", 32'(hi_cnt), 32'd0);

        // Stop in DEAD, then stop together with start in IDLE.
        pulse_start(0, 6);
        req = 4'b1000; tick(); req = '0;
        wait_trig(10);
        run(9);
        check_eq("s5_in_dead", 32'(trigger == 1'b0 && busy == 1'b1), 32'd1);
        stop = 1'b1; tick(); stop = 1'b0;
        check_eq("s5_idle_after_dead_stop", 32'(busy), 32'd0);
        n_trig = CW'(2); stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        check_eq("s5_stop_wins", 32'(busy), 32'd0);
        run(3);

        // Asynchronous reset in the middle of a pulse.
        pulse_start(0, 2);
        req = 4'b0010; tick(); req = '0;
        wait_trig(10);
        tick();
        #2;
        rst = 1'b0;
        model_reset();
        prev_trig = 0;
        #1;
        compare_all();
        check_eq("s6_trig_async",  32'(trigger),    32'd0);
        check_eq("s6_busy_async",  32'(busy),       32'd0);
        check_eq("s6_count_async", 32'(trig_count), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        pulse_start(0, 1);
        req = 4'b0100; tick(); req = '0;
        check_eq("s6_lat_early", 32'(trigger), 32'd0);
        tick();
        check_eq("s6_lat_trig",  32'(trigger),  32'd1);
        check_eq("s6_lat_grant", 32'(grant_id), 32'd2);
        stop = 1'b1; tick(); stop = 1'b0;
        run(12);

        // Random traffic, including mid-run config changes.
        for (int c = 0; c < 1500; c++) begin
            start    = ($urandom_range(0, 19) == 0);
            stop     = ($urandom_range(0, 59) == 0);
            n_trig   = CW'($urandom_range(0, 4));
            deadtime = CW'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 7) == 0);
            tick();
        end
        start = 1'b0; stop = 1'b0; req = '0;
        run(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
